// File: rtl/mult_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arbiter_pkg
//  Description : Shared controller state encodings and fixed-point datapath
//                defaults used by the multiplier arbiter and sibling
//                datapath controllers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_arbiter_pkg;

    // Default Q-format: 32-bit words with 24 fractional bits (Q8.24)
    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 24;

    // Controller state encoding shared by the datapath controllers
    typedef logic [1:0] state_t;

    localparam state_t c_IDLE = 2'd0;
    localparam state_t c_MUL  = 2'd1;
    localparam state_t c_HOLD = 2'd2;

endpackage : mult_arbiter_pkg
`default_nettype wire

// File: rtl/mult_2in.sv
`default_nettype none
// ============================================================================
//  Module      : mult_2in
//  Description : Combinational signed fixed-point multiplier. Forms the full
//                2*WIDTH product and returns bits [FRAC+WIDTH-1:FRAC]
//                (floor rounding, silent wrap on overflow).
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_2in
    import mult_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_res
);

    logic signed [2*WIDTH-1:0] w_a_ext;
    logic signed [2*WIDTH-1:0] w_b_ext;
    logic signed [2*WIDTH-1:0] w_prod;

    // Sign-extend both operands so the multiply is a full-width signed product
    assign w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Arithmetic shift drops the fraction (floor), the cast wraps the integer part
    assign o_res = WIDTH'(w_prod >>> FRAC);

endmodule : mult_2in
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arbiter
//  Description : Shares one fixed-point multiplier between N requesters via a
//                round-robin grant. IDLE accepts one operand pair, MUL
//                registers the product, HOLD presents it until consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC,
    parameter int N     = 4,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            i_valid,
    input  logic [N*WIDTH-1:0]      i_a,
    input  logic [N*WIDTH-1:0]      i_b,
    output logic [N-1:0]            o_ready,
    output logic                    o_valid,
    output logic [IDW-1:0]          o_id,
    output logic signed [WIDTH-1:0] o_res,
    input  logic                    i_res_ready,
    output logic                    o_busy
);

    state_t                  r_state;
    state_t                  w_next_state;

    logic [IDW-1:0]          r_ptr;
    logic signed [WIDTH-1:0] r_a;
    logic signed [WIDTH-1:0] r_b;
    logic [IDW-1:0]          r_id;

    logic                    r_valid;
    logic [IDW-1:0]          r_out_id;
    logic signed [WIDTH-1:0] r_res;

    logic                    w_found;
    logic [IDW-1:0]          w_grant_id;
    logic [N-1:0]            w_grant_onehot;
    logic                    w_accept;
    int                      w_sum;
    logic [IDW-1:0]          w_idx;
    logic signed [WIDTH-1:0] w_prod;

    // Round-robin search: first valid requester at or above r_ptr, modulo N
    always_comb begin
        w_found        = 1'b0;
        w_grant_id     = '0;
        w_sum          = 0;
        w_idx          = '0;
        w_grant_onehot = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = int'(r_ptr) + i;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = IDW'(w_sum);
            if (!w_found && i_valid[w_idx]) begin
                w_found    = 1'b1;
                w_grant_id = w_idx;
            end
        end
        w_grant_onehot[w_grant_id] = w_found;
    end

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> MUL on a grant, MUL -> HOLD, HOLD -> IDLE when consumed
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_found)     w_next_state = c_MUL;
            c_MUL:                    w_next_state = c_HOLD;
            c_HOLD:  if (i_res_ready) w_next_state = c_IDLE;
            default:                  w_next_state = c_IDLE;
        endcase
    end

    // Outputs: grant strobe only in IDLE and never while reset is asserted
    always_comb begin
        w_accept = (r_state == c_IDLE) && w_found && rst;
        o_ready  = w_accept ? w_grant_onehot : '0;
        o_busy   = (r_state != c_IDLE);
    end

    // Shared multiplier works on the latched operand pair
    mult_2in #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mult (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_res (w_prod)
    );

    // Datapath: latch winner on accept, capture product in MUL, release in HOLD
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_id     <= '0;
            r_valid  <= 1'b0;
            r_out_id <= '0;
            r_res    <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= i_a[w_grant_id*WIDTH +: WIDTH];
                r_b   <= i_b[w_grant_id*WIDTH +: WIDTH];
                r_id  <= w_grant_id;
                r_ptr <= (w_grant_id == IDW'(N-1)) ? '0 : w_grant_id + IDW'(1);
            end
            if (r_state == c_MUL) begin
                r_res    <= w_prod;
                r_out_id <= r_id;
                r_valid  <= 1'b1;
            end else if ((r_state == c_HOLD) && i_res_ready) begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_id    = r_out_id;
    assign o_res   = r_res;

endmodule : mult_arbiter
`default_nettype wire

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, operand and result width; FRAC, default 24, fractional bits; N, default 4, requester count; IDW, default 2, requester-id width (clog2 N).
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-005 Port i_valid SHALL be an input, N bits: per-requester operand-pair valid.
REQ-006 Port i_a SHALL be an input, N*WIDTH bits: signed operand a, with requester k at bits [k*WIDTH +: WIDTH].
REQ-007 Port i_b SHALL be an input, N*WIDTH bits: signed operand b, packed like i_a.
REQ-008 Port o_ready SHALL be an output, N bits: per-requester accept strobe.
REQ-009 Port o_valid SHALL be an output, 1 bit: result valid.
REQ-010 Port o_id SHALL be an output, IDW bits: index of the requester owning o_res.
REQ-011 Port o_res SHALL be an output, WIDTH bits, signed: fixed-point product.
REQ-012 Port i_res_ready SHALL be an input, 1 bit: result-consumer ready.
REQ-013 Port o_busy SHALL be an output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The block SHALL share one fixed-point multiplier among N requesters through a round-robin grant.
REQ-015 The FSM SHALL have three states: IDLE, MUL and HOLD.
REQ-016 In IDLE with any i_valid bit high, the block SHALL select a winner combinationally, assert o_ready for the winner only in that cycle, latch its i_a, i_b and id, and go to MUL.
REQ-017 A transfer SHALL occur only when i_valid[k] and o_ready[k] are both high; o_ready SHALL be all-zero outside IDLE.
REQ-018 In IDLE with no i_valid bit high, the block SHALL stay in IDLE with no grant.
REQ-019 In MUL, the block SHALL register the product into o_res, set o_valid=1, drive o_id with the latched id, and go to HOLD.
REQ-020 In HOLD, o_valid, o_res and o_id SHALL stay stable until i_res_ready=1.
REQ-021 In a HOLD cycle with i_res_ready=1, the block SHALL complete the transfer, drive o_valid to 0 on the next edge, and return to IDLE.
REQ-022 Latency SHALL be 2 cycles from the accept edge to o_valid high; best-case throughput SHALL be one result per 3 cycles.
REQ-023 The arithmetic SHALL be a full signed 2*WIDTH product with o_res = product[FRAC+WIDTH-1 : FRAC]: truncation toward minus infinity, silent wrap on overflow, no saturation.
REQ-024 Round-robin priority SHALL be held in a pointer ptr (IDW bits), and the search SHALL start at ptr and go upward modulo N.
REQ-025 After each grant to k, ptr SHALL become (k+1) mod N, wrapping from N-1 to 0.
REQ-026 ptr SHALL NOT change when no grant occurs.
REQ-027 i_valid changes during MUL or HOLD SHALL have no effect; pending requests are re-arbitrated in the next IDLE.
REQ-028 A requester that drops i_valid before being granted SHALL lose its place with no side effect.
REQ-029 i_res_ready high outside HOLD SHALL be ignored.

Reset
REQ-030 When rst=0 at a clock edge, the block SHALL set state=IDLE, ptr=0, o_valid=0, o_res=0, o_id=0, o_busy=0 and the latched operands to 0.
REQ-031 o_ready SHALL be 0 throughout any cycle with rst=0, including reset asserted during MUL or HOLD.
REQ-032 A result in flight at reset SHALL be discarded and never presented.
REQ-033 In the first cycle after rst returns to 1, requester 0 SHALL have highest priority.

Structure
REQ-034 The state encodings (IDLE=2'd0, MUL=2'd1, HOLD=2'd2) and the WIDTH/FRAC defaults SHALL reside in a shared package used by other datapath controllers.
REQ-035 The multiplier SHALL be one instance of the existing mult_2in sub-module, with WIDTH and FRAC passed through, fed from the latched operands, and its output registered in MUL.
REQ-036 The arbiter SHALL be written inline.

Verification
REQ-037 Basic product: requester 2 only, a=0x01800000 (1.5), b=0x02000000 (2.0) -> o_ready[2] high for 1 cycle; 2 cycles later o_valid=1, o_id=2, o_res=0x03000000.
REQ-038 Sign and truncation: a=0xFF000000 (-1.0), b=0x00800000 (0.5) -> o_res=0xFF800000.
REQ-039 Wrap on overflow: a=b=0x7F000000 (127.0) -> o_res=0x01000000, no saturation.
REQ-040 Fairness: all four i_valid held high, i_res_ready=1 -> grants 0,1,2,3,0,1 in that order, one grant every 3 cycles.
REQ-041 Backpressure: i_res_ready=0 for 5 cycles in HOLD -> o_valid, o_res and o_id constant and o_ready=0 throughout; accept completes on the first cycle with i_res_ready=1.
REQ-042 Reset mid-operation: rst=0 during MUL after a grant to requester 3 -> next cycle o_valid=0, o_busy=0, state IDLE; after rst=1 with requesters 1 and 3 valid, requester 1 is granted first (ptr=0).
